// File: rtl/opr1_sequencer.sv
// PDP-8 Group 1 operate sequencer: captures IR/AC/Link and steps through the
// enabled micro-operations (clear, complement, increment, rotate/swap) in event order.

module opr1_clorin (
  input  logic [11:0] a,
  input  logic [11:0] d,
  input  logic        clr,
  input  logic        dor,
  input  logic        inv,
  output logic [11:0] y
);

  assign y = ((clr ? 12'd0 : a) | (dor ? d : 12'd0)) ^ {12{inv}};

endmodule

module opr1_sequencer (
  input  logic        CLK,
  input  logic        RESET_,
  input  logic        START,
  input  logic [11:0] IR,
  input  logic [11:0] AC_IN,
  input  logic        L_IN,
  output logic [11:0] AC_OUT,
  output logic        L_OUT,
  output logic        AC_LD,
  output logic        BUSY,
  output logic        DONE,
  output logic        ERR
);

  typedef enum logic [2:0] {
    S_IDLE, S_CLEAR, S_COMPL, S_INCR, S_ROT1, S_ROT2, S_FIN, S_ERRS
  } state_e;

  state_e      state_q, state_d;
  logic [11:0] wac_q, wac_d;
  logic        wl_q, wl_d;
  logic [7:0]  wir_q, wir_d;
  logic [11:0] ac_out_q, ac_out_d;
  logic        l_out_q, l_out_d;
  logic        ac_ld_q, ac_ld_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic        err_q, err_d;

  logic [11:0] clorin_y;
  logic        clr_en, inv_en;
  logic [12:0] inc;
  logic [12:0] rot_r, rot_l;

  // First enabled micro-operation stage strictly after stage s; FIN when none remain.
  function automatic state_e next_after(input state_e s, input logic [7:0] ir);
    logic rot_en;
    rot_en = (ir[3] ^ ir[2]) | (~ir[3] & ~ir[2] & ir[1]);
    if (s == S_IDLE && (ir[7] | ir[6]))                   return S_CLEAR;
    if (s <= S_CLEAR && (ir[5] | ir[4]))                  return S_COMPL;
    if (s <= S_COMPL && ir[0])                            return S_INCR;
    if (s <= S_INCR && rot_en)                            return S_ROT1;
    return S_FIN;
  endfunction

  assign clr_en = (state_q == S_CLEAR) & wir_q[7];
  assign inv_en = (state_q == S_COMPL) & wir_q[5];

  opr1_clorin u_clorin (
    .a   (wac_q),
    .d   (12'd0),
    .clr (clr_en),
    .dor (1'b0),
    .inv (inv_en),
    .y   (clorin_y)
  );

  // {link, ac} treated as one 13-bit word for the rotates.
  assign rot_r = {wac_q[0], wl_q, wac_q[11:1]};
  assign rot_l = {wac_q, wl_q};

  // NOTE: every signal assigned here gets a default first, so no path leaves it
  // holding a value and no latch is inferred.
  always_comb begin
    state_d = state_q;
    wac_d   = wac_q;
    wl_d    = wl_q;
    wir_d   = wir_q;
    inc     = {1'b0, wac_q} + 13'd1;

    case (state_q)
      S_IDLE: begin
        if (START) begin
          wir_d = IR[7:0];
          wac_d = AC_IN;
          wl_d  = L_IN;
          if (IR[11:8] != 4'b1110) state_d = S_ERRS;
          else                     state_d = next_after(S_IDLE, IR[7:0]);
        end
      end
      S_CLEAR: begin
        wac_d   = clorin_y;
        if (wir_q[6]) wl_d = 1'b0;
        state_d = next_after(S_CLEAR, wir_q);
      end
      S_COMPL: begin
        wac_d   = clorin_y;
        if (wir_q[4]) wl_d = ~wl_q;
        state_d = next_after(S_COMPL, wir_q);
      end
      S_INCR: begin
        wac_d   = inc[11:0];
        if (inc[12]) wl_d = ~wl_q;
        state_d = next_after(S_INCR, wir_q);
      end
      S_ROT1: begin
        if (~wir_q[3] & ~wir_q[2]) wac_d = {wac_q[5:0], wac_q[11:6]};
        else if (wir_q[3])         {wl_d, wac_d} = rot_r;
        else                       {wl_d, wac_d} = rot_l;
        state_d = (wir_q[1] & (wir_q[3] ^ wir_q[2])) ? S_ROT2 : S_FIN;
      end
      S_ROT2: begin
        if (wir_q[3]) {wl_d, wac_d} = rot_r;
        else          {wl_d, wac_d} = rot_l;
        state_d = S_FIN;
      end
      default: state_d = S_IDLE;
    endcase

    // Outputs are registered copies of what the next state will present.
    done_d   = (state_d == S_FIN);
    ac_ld_d  = (state_d == S_FIN);
    err_d    = (state_d == S_ERRS);
    busy_d   = (state_d != S_IDLE);
    ac_out_d = (state_d == S_FIN) ? wac_d : 12'd0;
    l_out_d  = (state_d == S_FIN) ? wl_d : 1'b0;
  end

  // NOTE: sequential state uses non-blocking assignments only; the working
  // registers are plain flops, so they are cleared by reset like everything else.
  always_ff @(posedge CLK or negedge RESET_) begin
    if (!RESET_) begin
      state_q  <= S_IDLE;
      wac_q    <= 12'd0;
      wl_q     <= 1'b0;
      wir_q    <= 8'd0;
      ac_out_q <= 12'd0;
      l_out_q  <= 1'b0;
      ac_ld_q  <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      wac_q    <= wac_d;
      wl_q     <= wl_d;
      wir_q    <= wir_d;
      ac_out_q <= ac_out_d;
      l_out_q  <= l_out_d;
      ac_ld_q  <= ac_ld_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      err_q    <= err_d;
    end
  end

  assign AC_OUT = ac_out_q;
  assign L_OUT  = l_out_q;
  assign AC_LD  = ac_ld_q;
  assign BUSY   = busy_q;
  assign DONE   = done_q;
  assign ERR    = err_q;

endmodule

// File: tb/tb_opr1_sequencer.sv
// Directed bench for opr1_sequencer: hand-computed OPR results, latencies,
// busy/ignore behaviour, mid-operation reset and the illegal-IR path.

module tb_opr1_sequencer;

  logic        CLK = 1'b0;
  logic        RESET_;
  logic        START;
  logic [11:0] IR;
  logic [11:0] AC_IN;
  logic        L_IN;
  logic [11:0] AC_OUT;
  logic        L_OUT;
  logic        AC_LD;
  logic        BUSY;
  logic        DONE;
  logic        ERR;

  int n_checks = 0;
  int n_fail   = 0;

  opr1_sequencer dut (
    .CLK    (CLK),
    .RESET_ (RESET_),
    .START  (START),
    .IR     (IR),
    .AC_IN  (AC_IN),
    .L_IN   (L_IN),
    .AC_OUT (AC_OUT),
    .L_OUT  (L_OUT),
    .AC_LD  (AC_LD),
    .BUSY   (BUSY),
    .DONE   (DONE),
    .ERR    (ERR)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0o expected %0o", tag, got, exp);
    end
  endtask

  // Called at a negedge; starts an op at once and returns at the negedge after DONE.
  task automatic run_op(input string tag, input logic [11:0] ir, input logic [11:0] ac,
                        input logic l, input logic [11:0] exp_ac, input logic exp_l,
                        input int exp_lat);
    int lat;
    START = 1'b1; IR = ir; AC_IN = ac; L_IN = l;
    @(posedge CLK);
    @(negedge CLK);
    START = 1'b0; IR = 12'o0; AC_IN = 12'o0; L_IN = 1'b0;
    lat = 1;
    check({tag, "_busy"}, BUSY, 1);
    while (!DONE && lat < 12) begin
      @(negedge CLK);
      lat++;
    end
    check({tag, "_latency"}, lat, exp_lat);
    check({tag, "_ac"}, AC_OUT, exp_ac);
    check({tag, "_l"}, L_OUT, exp_l);
    check({tag, "_ac_ld"}, AC_LD, 1);
    check({tag, "_err"}, ERR, 0);
    @(negedge CLK);
    check({tag, "_done_fall"}, DONE, 0);
    check({tag, "_ac_ld_fall"}, AC_LD, 0);
    check({tag, "_ac_zero"}, AC_OUT, 0);
    check({tag, "_idle"}, BUSY, 0);
  endtask

  initial begin
    int dones;
    RESET_ = 1'b0; START = 1'b0; IR = 12'o0; AC_IN = 12'o0; L_IN = 1'b0;
    repeat (3) @(negedge CLK);
    check("rst_ac_out", AC_OUT, 0);
    check("rst_ctrl", {L_OUT, AC_LD, BUSY, DONE, ERR}, 0);
    RESET_ = 1'b1;
    @(negedge CLK);

    run_op("cla",     12'o7200, 12'o5252, 1'b1, 12'o0000, 1'b1, 2);
    run_op("cia",     12'o7041, 12'o0001, 1'b0, 12'o7777, 1'b0, 3);
    run_op("iac_wrap",12'o7001, 12'o7777, 1'b0, 12'o0000, 1'b1, 2);
    run_op("rtr",     12'o7012, 12'o0001, 1'b0, 12'o4000, 1'b0, 3);
    run_op("bsw",     12'o7002, 12'o0077, 1'b1, 12'o7700, 1'b1, 2);
    run_op("rar_ral", 12'o7014, 12'o1234, 1'b1, 12'o1234, 1'b1, 1);
    run_op("nop",     12'o7000, 12'o4321, 1'b0, 12'o4321, 1'b0, 1);
    run_op("ral",     12'o7004, 12'o4000, 1'b0, 12'o0000, 1'b1, 2);
    run_op("rtl",     12'o7006, 12'o4000, 1'b0, 12'o0001, 1'b0, 3);
    run_op("cll_cml", 12'o7120, 12'o0007, 1'b1, 12'o0007, 1'b1, 3);
    run_op("full",    12'o7341, 12'o5555, 1'b1, 12'o0000, 1'b1, 4);
    run_op("max",     12'o7273, 12'o1111, 1'b1, 12'o2000, 1'b0, 6);

    // START held through the CLEAR and FIN cycles must be ignored.
    START = 1'b1; IR = 12'o7300; AC_IN = 12'o1234; L_IN = 1'b1;
    @(posedge CLK);
    @(negedge CLK);
    IR = 12'o7001; AC_IN = 12'o0005;
    @(negedge CLK);
    check("busy_done", DONE, 1);
    check("busy_ac", AC_OUT, 12'o0000);
    check("busy_l", L_OUT, 0);
    @(negedge CLK);
    START = 1'b0;
    check("busy_ignored_idle", BUSY, 0);
    dones = 0;
    repeat (8) begin
      @(negedge CLK);
      if (DONE) dones++;
    end
    check("busy_no_second_done", dones, 0);

    // Reset during the CLEAR cycle of 7341.
    START = 1'b1; IR = 12'o7341; AC_IN = 12'o5555; L_IN = 1'b1;
    @(posedge CLK);
    @(negedge CLK);
    START = 1'b0;
    check("rst_mid_busy_before", BUSY, 1);
    RESET_ = 1'b0;
    #1;
    check("rst_mid_busy", BUSY, 0);
    check("rst_mid_done", DONE, 0);
    check("rst_mid_ac_ld", AC_LD, 0);
    check("rst_mid_ac_out", AC_OUT, 0);
    @(negedge CLK);
    RESET_ = 1'b1;
    dones = 0;
    repeat (8) begin
      @(negedge CLK);
      if (DONE || AC_LD) dones++;
    end
    check("rst_mid_no_done", dones, 0);
    check("rst_mid_idle", BUSY, 0);

    // Non-Group-1 instruction.
    START = 1'b1; IR = 12'o6001; AC_IN = 12'o7777; L_IN = 1'b1;
    @(posedge CLK);
    @(negedge CLK);
    START = 1'b0;
    check("ill_err", ERR, 1);
    check("ill_done", DONE, 0);
    check("ill_ac_ld", AC_LD, 0);
    check("ill_ac_out", AC_OUT, 0);
    check("ill_busy", BUSY, 1);
    @(negedge CLK);
    check("ill_err_fall", ERR, 0);
    check("ill_idle", BUSY, 0);

    run_op("after_err", 12'o7040, 12'o0000, 1'b0, 12'o7777, 1'b0, 2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
